// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - memory-mapped GPIO with atomic output ops, write-protected direction and edge interrupts
//
// Purpose : GPIO controller on the simple wr/rd peripheral bus. Pads are synchronised
//           (optionally debounced when GPIO_DEBOUNCE_EN is defined), edge-detected and
//           latched into a W1C status register that drives a single level interrupt.
// Macro   : GPIO_DEBOUNCE_EN - per-pin stability counters in front of IN.
// Ports   : clk, rst (async, active-high)
//           wr_en, wr_addr_i, wr_data_i    - register write, offset in addr[5:2]
//           rd_en, rd_addr_i, rd_data_o    - register read, rd_data_o registered
//           gpio_i                         - asynchronous pad inputs
//           gpio_o, gpio_t                 - pad output values / tristate enables (1 = input)
//           irq_o                          - level interrupt, registered
module gpio_irq #(
   parameter int          AW                   = 32,
   parameter int          DW                   = 32,
   parameter int          GPIO_WIDTH           = 32,
   parameter int          SYNC_STAGES          = 2,
   parameter logic [31:0] DEFAULT_OUTPUT_VALUE = 32'h0000_0000,
   parameter logic [31:0] DEFAULT_DIRECT       = 32'hffff_ffff,
   parameter logic [31:0] DIR_WRITABLE         = 32'hffff_ffff,
   parameter int          DEBOUNCE_CYCLES      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DW-1:0]         wr_data_i,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DW-1:0]         rd_data_o,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_t,
   output logic                  irq_o
);

   localparam logic [3:0] OFF_OUT        = 4'h0;
   localparam logic [3:0] OFF_OUT_SET    = 4'h1;
   localparam logic [3:0] OFF_OUT_CLR    = 4'h2;
   localparam logic [3:0] OFF_OUT_TGL    = 4'h3;
   localparam logic [3:0] OFF_DIR        = 4'h4;
   localparam logic [3:0] OFF_IN         = 4'h5;
   localparam logic [3:0] OFF_IRQ_EN     = 4'h6;
   localparam logic [3:0] OFF_IRQ_RISE   = 4'h7;
   localparam logic [3:0] OFF_IRQ_FALL   = 4'h8;
   localparam logic [3:0] OFF_IRQ_STATUS = 4'h9;

   localparam logic [GPIO_WIDTH-1:0] OUT_RST  = DEFAULT_OUTPUT_VALUE[GPIO_WIDTH-1:0];
   localparam logic [GPIO_WIDTH-1:0] DIR_RST  = DEFAULT_DIRECT[GPIO_WIDTH-1:0];
   localparam logic [GPIO_WIDTH-1:0] DIR_MASK = DIR_WRITABLE[GPIO_WIDTH-1:0];

   logic [3:0]            wr_off;
   logic [3:0]            rd_off;
   logic [GPIO_WIDTH-1:0] wdata;

   logic [GPIO_WIDTH-1:0] out_q;
   logic [GPIO_WIDTH-1:0] dir_q;
   logic [GPIO_WIDTH-1:0] irq_en_q;
   logic [GPIO_WIDTH-1:0] irq_rise_q;
   logic [GPIO_WIDTH-1:0] irq_fall_q;
   logic [GPIO_WIDTH-1:0] irq_status_q;

   logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [GPIO_WIDTH-1:0] sync_val;
   logic [GPIO_WIDTH-1:0] in_val;
   logic [GPIO_WIDTH-1:0] prev_q;
   logic [GPIO_WIDTH-1:0] rise;
   logic [GPIO_WIDTH-1:0] fall;
   logic [GPIO_WIDTH-1:0] set_ev;
   logic [GPIO_WIDTH-1:0] w1c;
   logic [DW-1:0]         rd_mux;

   assign wr_off = wr_addr_i[5:2];
   assign rd_off = rd_addr_i[5:2];
   assign wdata  = wr_data_i[GPIO_WIDTH-1:0];

   // Address bits outside the offset field are don't-care for this block.
   logic unused_addr;
   assign unused_addr = &{1'b0, wr_addr_i[AW-1:6], wr_addr_i[1:0],
                          rd_addr_i[AW-1:6], rd_addr_i[1:0]};

   generate
      if (DW > GPIO_WIDTH) begin : g_unused_data
         logic unused_wdata;
         assign unused_wdata = &{1'b0, wr_data_i[DW-1:GPIO_WIDTH]};
      end
   endgenerate

   assign gpio_o = out_q;
   assign gpio_t = dir_q;

   // ------------------------------------------------------------------
   // Input synchroniser
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gpio_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_val = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0]         db_cnt_q [GPIO_WIDTH];
   logic [GPIO_WIDTH-1:0] db_in_q;

   // The counter runs only while the synchronised value disagrees with IN;
   // the edge on which it would reach DEBOUNCE_CYCLES commits the new value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_in_q <= '0;
         for (int i = 0; i < GPIO_WIDTH; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (sync_val[i] == db_in_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
               db_in_q[i]  <= sync_val[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign in_val = db_in_q;
`else
   logic unused_db;
   assign unused_db = (DEBOUNCE_CYCLES == 0);
   assign in_val    = sync_val;
`endif

   // ------------------------------------------------------------------
   // Edge detection
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= '0;
      else     prev_q <= in_val;
   end

   assign rise   = in_val & ~prev_q;
   assign fall   = ~in_val & prev_q;
   assign set_ev = (rise & irq_rise_q) | (fall & irq_fall_q);
   assign w1c    = (wr_en && wr_off == OFF_IRQ_STATUS) ? wdata : '0;

   // ------------------------------------------------------------------
   // Register writes
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q      <= OUT_RST;
         dir_q      <= DIR_RST;
         irq_en_q   <= '0;
         irq_rise_q <= '0;
         irq_fall_q <= '0;
      end else if (wr_en) begin
         case (wr_off)
            OFF_OUT:      out_q      <= wdata;
            OFF_OUT_SET:  out_q      <= out_q | wdata;
            OFF_OUT_CLR:  out_q      <= out_q & ~wdata;
            OFF_OUT_TGL:  out_q      <= out_q ^ wdata;
            OFF_DIR:      dir_q      <= (wdata & DIR_MASK) | (DIR_RST & ~DIR_MASK);
            OFF_IRQ_EN:   irq_en_q   <= wdata;
            OFF_IRQ_RISE: irq_rise_q <= wdata;
            OFF_IRQ_FALL: irq_fall_q <= wdata;
            default: ;
         endcase
      end
   end

   // New events are OR-ed in after the clear so a coincident event survives W1C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_status_q <= '0;
         irq_o        <= 1'b0;
      end else begin
         irq_status_q <= (irq_status_q & ~w1c) | set_ev;
         irq_o        <= |(irq_status_q & irq_en_q);
      end
   end

   // ------------------------------------------------------------------
   // Register reads
   // ------------------------------------------------------------------
   always_comb begin
      rd_mux = '0;
      case (rd_off)
         OFF_OUT:        rd_mux[GPIO_WIDTH-1:0] = out_q;
         OFF_DIR:        rd_mux[GPIO_WIDTH-1:0] = dir_q;
         OFF_IN:         rd_mux[GPIO_WIDTH-1:0] = in_val;
         OFF_IRQ_EN:     rd_mux[GPIO_WIDTH-1:0] = irq_en_q;
         OFF_IRQ_RISE:   rd_mux[GPIO_WIDTH-1:0] = irq_rise_q;
         OFF_IRQ_FALL:   rd_mux[GPIO_WIDTH-1:0] = irq_fall_q;
         OFF_IRQ_STATUS: rd_mux[GPIO_WIDTH-1:0] = irq_status_q;
         default:        rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data_o <= '0;
      else if (rd_en) rd_data_o <= rd_mux;
   end

endmodule
